synchronizer: RTL and testbench
===============================

Name: synchronizer

Overview:
- Multi-bit, multi-stage flip-flop synchronizer that brings a bus from a foreign clock domain into the i_clk domain.
- Its main use is in the asynchronous FIFO, carrying Gray-coded read/write pointers across domains; it may also carry quasi-static configuration buses.
- It reduces metastability probability only. It does not guarantee bus coherency; the source must change at most one bit per destination cycle (Gray code) or hold the value stable.

Parameters:
- WIDTH, 16, bit width of i_data/o_data; legal range 1..1024.
- STAGES, 2, number of flip-flop stages in the chain; legal minimum 2.
- RESET_VALUE, all-zeros (WIDTH bits), value loaded into every stage on reset.

Ports:
- i_clk  input  1  destination-domain clock; all state updates on its rising edge.
- i_rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_data  input  WIDTH  asynchronous input bus from the source domain.
- o_data  output  WIDTH  synchronized bus; driven directly by the last stage register.

Behaviour:
- Structure: a chain of STAGES registers, each WIDTH bits wide.
  - stage[0] <= i_data.
  - stage[k] <= stage[k-1] for k = 1..STAGES-1.
  - o_data = stage[STAGES-1].
- No logic between stages; no combinational path from i_data to o_data.
- Reset:
  - While i_rst = 0, every stage (and therefore o_data) immediately holds RESET_VALUE, independent of i_clk.
  - Reset assertion is asynchronous; it takes effect mid-cycle and overrides any pending capture.
  - Reset deassertion is expected synchronous to i_clk (the reset bridge is external). The first capture occurs on the first rising edge with i_rst = 1.
- Latency:
  - A value on i_data, stable from before rising edge N, appears on o_data just after edge N+STAGES-1.
  - With STAGES = 2: stable before edge N, visible after edge N+1, i.e. within 2 rising edges of being applied.
- Throughput: a new value every cycle passes through in order; nothing is dropped or reordered when inputs are setup-compliant.
- Hold: o_data is constant while i_data is constant (after the pipeline fills).
- Width rules:
  - Each bit is synchronized independently and identically.
  - No arithmetic, encoding or bus-coherency logic.
  - Bit i of o_data comes only from bit i of i_data.
- Parameter checks:
  - Elaboration error if STAGES < 2 or WIDTH < 1.
  - RESET_VALUE is truncated or extended to WIDTH bits.
- Synthesis intent:
  - Stage registers carry the ASYNC_REG (or tool-equivalent) attribute so they are placed adjacently.
  - Registers must not be retimed or merged into shift-register primitives.
- Simulation: no X propagates after reset unless i_data itself is X.

Test Plan:
- Reset hold: drive i_rst = 0 for 5 cycles with i_data = 16'hFFFF -> o_data = 16'h0000 throughout, including between clock edges.
- Latency (WIDTH=16, STAGES=2): release reset, then 3 ns after an edge set i_data = 16'hA5C3.
  - 3 ns after the next edge -> o_data still the previous value.
  - 3 ns after the second edge -> o_data = 16'hA5C3.
- Random sweep: 100 iterations, each applies a random i_data in 0..65535, waits 2 rising edges plus 3 ns -> o_data equals the applied value every iteration.
- Back-to-back: change i_data every cycle through 1, 2, 3, 4 -> o_data presents 1, 2, 3, 4 on consecutive cycles, delayed by 2 edges.
- Async reset mid-stream: with o_data = 16'h1234, pull i_rst low between edges.
  - o_data = 16'h0000 immediately, before the next edge.
  - After release and 2 edges, o_data tracks i_data again.
- Parameter variant: STAGES = 3, WIDTH = 1, RESET_VALUE = 1 -> o_data = 1 during reset; a 0 on i_data appears after 3 edges.

Source files
------------

// File: rtl/synchronizer.sv
// Multi-bit, multi-stage flip-flop synchronizer bringing a bus into the i_clk domain.
// Bits are synchronized independently; the source must Gray-code or hold the bus stable.
module synchronizer #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("synchronizer: STAGES must be at least 2");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("synchronizer: WIDTH must be at least 1");
    end
  endgenerate

  // Kept as discrete, adjacent registers: no retiming, no SRL inference.
  (* ASYNC_REG = "TRUE", shreg_extract = "no", dont_retime = "true" *)
  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = i_data;
    for (int k = 1; k < int'(STAGES); k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        stage_q[k] <= RESET_VALUE;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign o_data = stage_q[STAGES-1];

endmodule

// File: tb/tb_synchronizer.sv
// Directed bench for synchronizer: default 16-bit/2-stage instance plus a
// 1-bit/3-stage instance with a non-zero reset value.
module tb_synchronizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = 16'h0000;
  logic [15:0] dout;

  logic        rst_v = 1'b1;
  logic [0:0]  data_v = 1'b0;
  logic [0:0]  dout_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  synchronizer #(.WIDTH(16), .STAGES(2)) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data (data),
    .o_data (dout)
  );

  synchronizer #(.WIDTH(1), .STAGES(3), .RESET_VALUE(1'b1)) u_dut_v (
    .i_clk  (clk),
    .i_rst  (rst_v),
    .i_data (data_v),
    .o_data (dout_v)
  );

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic test_reset();
    data  = 16'hFFFF;
    rst   = 1'b0;
    rst_v = 1'b0;
    #1;
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async_assert: got %h expected %h", dout, 16'h0000);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (dout !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold_edge[%0d]: got %h expected %h", i, dout, 16'h0000);
      end
      #4;
      checks++;
      if (dout !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold_mid[%0d]: got %h expected %h", i, dout, 16'h0000);
      end
    end
  endtask

  task automatic test_latency();
    step();
    data = 16'h0000;
    rst  = 1'b1;
    step();
    step();
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL latency_fill: got %h expected %h", dout, 16'h0000);
    end
    data = 16'hA5C3;
    step();
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL latency_edge1: got %h expected %h", dout, 16'h0000);
    end
    step();
    checks++;
    if (dout !== 16'hA5C3) begin
      errors++;
      $display("FAIL latency_edge2: got %h expected %h", dout, 16'hA5C3);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 100; i++) begin
      v = 16'($urandom_range(0, 65535));
      data = v;
      step();
      step();
      checks++;
      if (dout !== v) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, dout, v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        exp = 16'(i - 1);
        checks++;
        if (dout !== exp) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got %h expected %h", i, dout, exp);
        end
      end
      if (i < 4) data = 16'(i + 1);
      step();
    end
  endtask

  task automatic test_async_reset();
    data = 16'h1234;
    step();
    step();
    checks++;
    if (dout !== 16'h1234) begin
      errors++;
      $display("FAIL async_pre: got %h expected %h", dout, 16'h1234);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL async_immediate: got %h expected %h", dout, 16'h0000);
    end
    step();
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL async_held: got %h expected %h", dout, 16'h0000);
    end
    rst  = 1'b1;
    data = 16'h5678;
    step();
    step();
    checks++;
    if (dout !== 16'h5678) begin
      errors++;
      $display("FAIL async_recover: got %h expected %h", dout, 16'h5678);
    end
  endtask

  task automatic test_param_variant();
    data_v = 1'b0;
    step();
    checks++;
    if (dout_v !== 1'b1) begin
      errors++;
      $display("FAIL variant_reset_edge: got %b expected %b", dout_v, 1'b1);
    end
    #4;
    checks++;
    if (dout_v !== 1'b1) begin
      errors++;
      $display("FAIL variant_reset_mid: got %b expected %b", dout_v, 1'b1);
    end
    step();
    rst_v = 1'b1;
    step();
    checks++;
    if (dout_v !== 1'b1) begin
      errors++;
      $display("FAIL variant_edge1: got %b expected %b", dout_v, 1'b1);
    end
    step();
    checks++;
    if (dout_v !== 1'b1) begin
      errors++;
      $display("FAIL variant_edge2: got %b expected %b", dout_v, 1'b1);
    end
    step();
    checks++;
    if (dout_v !== 1'b0) begin
      errors++;
      $display("FAIL variant_edge3: got %b expected %b", dout_v, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_param_variant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
